instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Autonomous instruction issuer that drives the `cpu` block's `s`/`load`/`in` start handshake and watches its `w`/`out`/`N`/`V`/`Z` results. It replaces hand-timed stimulus with a small writable program memory. On `go` it loads and starts each instruction in turn, waits for completion, and captures the datapath result and status flags. It sits directly in front of `cpu` in lab top levels and in automated benches.

## Interface
- `DEPTH`, default 16: program memory words; a power of two.
- `AW`, default 4: address width, equal to log2(`DEPTH`).
- `TIMEOUT`, default 64: maximum cycles allowed in each CPU wait phase.

Ports:
- `clk` in 1: the single clock; all state changes on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `go` in 1: start a run from address 0; sampled only in IDLE or DONE.
- `prog_we` in 1: program-memory write enable; ignored while `busy`.
- `prog_addr` in AW: program write address.
- `prog_data` in 16: program write data.
- `cpu_w` in 1: `cpu` wait flag; 1 means idle in the wait state.
- `cpu_out` in 16: `cpu` datapath output.
- `cpu_N`, `cpu_V`, `cpu_Z` in 1 each: `cpu` status flags.
- `cpu_s` out 1: start request to `cpu`.
- `cpu_load` out 1: instruction-register load to `cpu`.
- `cpu_in` out 16: instruction word to `cpu`.
- `busy` out 1: a run is in progress.
- `done` out 1: the last run finished; sticky until the next accepted `go`.
- `err` out 1: a timeout occurred; sticky until the next accepted `go`.
- `pc` out AW: address of the current or last instruction.
- `result` out 16: last captured `cpu_out`.
- `flags` out 3: last captured `{N,V,Z}`.
- `icount` out AW+1: instructions completed in this run.

## Operation
- States: IDLE, FETCH, LOAD, START, RUN, CAPTURE, DONE.
- IDLE/DONE + `go`=1 → FETCH; clears `pc`, `icount`, `done`, `err`, `flags`, `result`.
- FETCH:
  - registers `cpu_in` <= mem[`pc`].
  - If mem[`pc`][15:13]==3'b111 (HALT), goes → DONE without issuing.
  - Otherwise → LOAD.
- LOAD: `cpu_load`=1 for exactly one cycle → START.
- START: `cpu_s`=1 until `cpu_w`=0 is sampled → RUN.
- RUN: `cpu_s`=0; wait for `cpu_w`=1 → CAPTURE.
- CAPTURE:
  - `result`<=`cpu_out`; `flags`<={`cpu_N`,`cpu_V`,`cpu_Z`}; `icount`++.
  - If `pc`==DEPTH-1 → DONE (no wrap); else `pc`++ → FETCH.
- Timeout: a per-phase counter, cleared on entry to START and to RUN.
  - If the counter reaches TIMEOUT in START or RUN: `err`=1, `cpu_s`=0 → DONE.
- `cpu_in` holds its value from FETCH through CAPTURE; it is never changed while `cpu_load` or `cpu_s` is high.
- `busy`=1 in every state except IDLE and DONE.
- A `go` while busy is ignored.
- A `prog_we` while busy is dropped; no memory write occurs.
- Program memory has no reset; its contents survive `reset`.

## Timing
- All outputs are 0 in reset; `cpu_in` resets to 16'h0000.
- Reset asserted mid-run immediately forces IDLE with reset output values. A `cpu` caught mid-instruction is the system reset's responsibility.
- Memory write is synchronous; a word written in cycle n is fetchable from cycle n+1.
- `go` at edge k → FETCH at k+1, LOAD at k+2 (`cpu_load` high), `cpu_s` high from k+3.
- Minimum per-instruction overhead is 4 cycles (FETCH, LOAD, START ≥1, CAPTURE) plus the CPU execute time.
- `result`, `flags` and `icount` update together in the cycle after CAPTURE's edge.
- `done` rises in the same cycle that `busy` falls.
- `cpu_w`=0 already sampled at START entry → RUN next cycle; `cpu_s` is high for exactly 1 cycle.

## Structure
- Shared package `seq_pkg`: state encoding, `HALT_OP`=3'b111, and the opcode field slice [15:13].
- One sub-module, `prog_mem`: DEPTH×16, synchronous write, combinational read.
- The FSM, timeout counter, and capture registers live in the top module.

## Test plan
- Program {16'hD004, 16'hC020, 16'hE000}, pulse `go`, with real `cpu` attached → `done`, `icount`=2, `result`=16'h0004, `pc`=2, `err`=0.
- Program mov r0,#4; mov r1,r0; cmp r0,r1 (16'hA801); HALT → `flags`=3'b001 (Z=1, N=0) at `done`.
- Program 16 non-HALT words → runs all 16, `icount`=16, `pc`=15, no wrap.
- Stub `cpu_w` held at 1 → `err`=1 and `done`=1 exactly TIMEOUT+1 cycles after START entry; `cpu_s`=0 afterwards.
- `prog_we` and `go` pulsed mid-run → memory unchanged, run unaffected. Assert `reset` mid-RUN → all outputs 0 next sample; memory intact on the next run.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: FSM states and instruction opcode decode.
package seq_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned OP_MSB = 15;
    localparam int unsigned OP_LSB = 13;
    localparam logic [2:0]  HALT_OP = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_START,
        ST_RUN,
        ST_CAPTURE,
        ST_DONE
    } seq_state_e;

    function automatic logic is_halt(input logic [WORD_W-1:0] instr);
        return instr[OP_MSB:OP_LSB] == HALT_OP;
    endfunction

endpackage

// File: rtl/prog_mem.sv
// Program memory: synchronous write, combinational read, no reset so contents survive system reset.
module prog_mem
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_c
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_c = mem_q[raddr_i];

endmodule

// File: rtl/instr_sequencer.sv
// Steps through program memory, issuing each word to the cpu via load/start handshake
// and capturing its result and flags; a per-phase watchdog aborts a stuck cpu.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned AW      = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              go,
    input  logic              prog_we,
    input  logic [AW-1:0]     prog_addr,
    input  logic [WORD_W-1:0] prog_data,
    input  logic              cpu_w,
    input  logic [WORD_W-1:0] cpu_out,
    input  logic              cpu_N,
    input  logic              cpu_V,
    input  logic              cpu_Z,
    output logic              cpu_s,
    output logic              cpu_load,
    output logic [WORD_W-1:0] cpu_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [AW-1:0]     pc,
    output logic [WORD_W-1:0] result,
    output logic [2:0]        flags,
    output logic [AW:0]       icount
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     pc_q, pc_d;
    logic [AW:0]       icount_q, icount_d;
    logic [WORD_W-1:0] result_q, result_d;
    logic [2:0]        flags_q, flags_d;
    logic [WORD_W-1:0] cpu_in_q, cpu_in_d;
    logic              cpu_s_q, cpu_s_d;
    logic              cpu_load_q, cpu_load_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [TW-1:0]     tmo_q, tmo_d;
    logic [WORD_W-1:0] mem_rdata_c;

    // Writes are only honoured while no run is in progress.
    prog_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_prog_mem (
        .clk     (clk),
        .we_i    (prog_we && !busy_q),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_c (mem_rdata_c)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        icount_d = icount_q;
        result_d = result_q;
        flags_d  = flags_q;
        cpu_in_d = cpu_in_q;
        err_d    = err_q;
        tmo_d    = tmo_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_d  = ST_FETCH;
                    pc_d     = '0;
                    icount_d = '0;
                    result_d = '0;
                    flags_d  = '0;
                    err_d    = 1'b0;
                end
            end
            ST_FETCH: begin
                cpu_in_d = mem_rdata_c;
                state_d  = is_halt(mem_rdata_c) ? ST_DONE : ST_LOAD;
            end
            ST_LOAD: begin
                state_d = ST_START;
                tmo_d   = '0;
            end
            ST_START: begin
                if (!cpu_w) begin
                    state_d = ST_RUN;
                    tmo_d   = '0;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RUN: begin
                if (cpu_w) begin
                    state_d = ST_CAPTURE;
                end else if (tmo_q == TW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_CAPTURE: begin
                result_d = cpu_out;
                flags_d  = {cpu_N, cpu_V, cpu_Z};
                icount_d = icount_q + (AW + 1)'(1);
                if (pc_q == AW'(DEPTH - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake and status flags are registered copies of the upcoming state.
        cpu_load_d = (state_d == ST_LOAD);
        cpu_s_d    = (state_d == ST_START);
        busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            pc_q       <= '0;
            icount_q   <= '0;
            result_q   <= '0;
            flags_q    <= '0;
            cpu_in_q   <= '0;
            cpu_s_q    <= 1'b0;
            cpu_load_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            icount_q   <= icount_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
            cpu_in_q   <= cpu_in_d;
            cpu_s_q    <= cpu_s_d;
            cpu_load_q <= cpu_load_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
        end
    end

    assign cpu_s    = cpu_s_q;
    assign cpu_load = cpu_load_q;
    assign cpu_in   = cpu_in_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign pc       = pc_q;
    assign result   = result_q;
    assign flags    = flags_q;
    assign icount   = icount_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a behavioural cpu stub (out = ~instr, {N,V,Z} = instr[2:0])
// plus a program-level reference model, directed vectors and randomized programs.
module tb_instr_sequencer;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned AW      = 4;
    localparam int unsigned TIMEOUT = 20;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              go = 1'b0;
    logic              prog_we = 1'b0;
    logic [AW-1:0]     prog_addr = '0;
    logic [15:0]       prog_data = '0;
    logic              cpu_w;
    logic [15:0]       cpu_out;
    logic              cpu_N, cpu_V, cpu_Z;
    logic              cpu_s, cpu_load;
    logic [15:0]       cpu_in;
    logic              busy, done, err;
    logic [AW-1:0]     pc;
    logic [15:0]       result;
    logic [2:0]        flags;
    logic [AW:0]       icount;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_sequencer #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .go        (go),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .cpu_w     (cpu_w),
        .cpu_out   (cpu_out),
        .cpu_N     (cpu_N),
        .cpu_V     (cpu_V),
        .cpu_Z     (cpu_Z),
        .cpu_s     (cpu_s),
        .cpu_load  (cpu_load),
        .cpu_in    (cpu_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .pc        (pc),
        .result    (result),
        .flags     (flags),
        .icount    (icount)
    );

    // cpu stub: leaves wait on s, stays busy stub_lat cycles, then presents ~ir and ir[2:0].
    logic [15:0] stub_ir, stub_out;
    logic [2:0]  stub_fl;
    logic        stub_w;
    int          stub_cnt;
    int          stub_lat = 2;
    bit          hang_start = 1'b0;
    bit          hang_run = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            stub_w   <= 1'b1;
            stub_cnt <= 0;
            stub_ir  <= '0;
            stub_out <= '0;
            stub_fl  <= '0;
        end else begin
            if (cpu_load) stub_ir <= cpu_in;
            if (stub_w) begin
                if (cpu_s && !hang_start) begin
                    stub_w   <= 1'b0;
                    stub_cnt <= stub_lat;
                end
            end else if (!hang_run) begin
                if (stub_cnt <= 1) begin
                    stub_w   <= 1'b1;
                    stub_out <= ~stub_ir;
                    stub_fl  <= stub_ir[2:0];
                end else begin
                    stub_cnt <= stub_cnt - 1;
                end
            end
        end
    end

    assign cpu_w   = stub_w;
    assign cpu_out = stub_out;
    assign cpu_N   = stub_fl[2];
    assign cpu_V   = stub_fl[1];
    assign cpu_Z   = stub_fl[0];

    logic [15:0] shadow [DEPTH];

    typedef struct {
        logic [15:0]   w0, w1, w2, w3;
        int            lat;
        logic [AW:0]   ic;
        logic [AW-1:0] pc;
        logic [15:0]   res;
        logic [2:0]    fl;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_prog();
        for (int a = 0; a < DEPTH; a++) begin
            @(negedge clk);
            prog_we   = 1'b1;
            prog_addr = AW'(a);
            prog_data = shadow[a];
        end
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic pulse_go();
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    // Program-level reference: walk the program until HALT or the last address.
    task automatic model(output logic [AW:0] ic, output logic [AW-1:0] pe,
                         output logic [15:0] res, output logic [2:0] fl, output logic [15:0] cin);
        bit stop;
        ic = '0; pe = '0; res = '0; fl = '0; stop = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            if (!stop) begin
                pe = AW'(a);
                if (shadow[a][15:13] == 3'b111) begin
                    stop = 1'b1;
                end else begin
                    res = ~shadow[a];
                    fl  = shadow[a][2:0];
                    ic  = ic + 1'b1;
                end
            end
        end
        cin = shadow[pe];
    endtask

    task automatic check_run(input string tag, input logic [AW:0] ic, input logic [AW-1:0] p,
                             input logic [15:0] r, input logic [2:0] f, input logic e);
        bit ok;
        wait_done(ok);
        chk({tag, ".done"}, 64'(ok), 64'd1);
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        chk({tag, ".err"}, 64'(err), 64'(e));
        chk({tag, ".icount"}, 64'(icount), 64'(ic));
        chk({tag, ".pc"}, 64'(pc), 64'(p));
        chk({tag, ".result"}, 64'(result), 64'(r));
        chk({tag, ".flags"}, 64'(flags), 64'(f));
    endtask

    task automatic wait_sig(input string tag, input bit want_s);
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (cpu_s === want_s) return;
        end
        chk({tag, ".wait_cpu_s"}, 64'(cpu_s), 64'(want_s));
    endtask

    function automatic logic [63:0] out_vec();
        return 64'({busy, done, err, cpu_s, cpu_load, pc, flags, icount, result, cpu_in});
    endfunction

    initial begin
        logic [AW:0]   e_ic;
        logic [AW-1:0] e_pc;
        logic [15:0]   e_res, e_cin;
        logic [2:0]    e_fl;
        int            n;
        bit            ok;

        vecs[0] = '{16'hD004, 16'hC020, 16'hE000, 16'hE000, 2, 5'd2, 4'd2, 16'h3FDF, 3'b000};
        vecs[1] = '{16'hE000, 16'h1111, 16'h2222, 16'hE000, 1, 5'd0, 4'd0, 16'h0000, 3'b000};
        vecs[2] = '{16'hA801, 16'hE123, 16'h0000, 16'hE000, 1, 5'd1, 4'd1, 16'h57FE, 3'b001};
        vecs[3] = '{16'h1235, 16'h4566, 16'h789F, 16'hE000, 3, 5'd3, 4'd3, 16'h8760, 3'b111};
        vecs[4] = '{16'h0007, 16'hFFFF, 16'h0000, 16'hE000, 4, 5'd1, 4'd1, 16'hFFF8, 3'b111};

        // Reset values.
        repeat (2) @(negedge clk);
        chk("reset.outputs", out_vec(), 64'd0);
        reset = 1'b1;

        // Start-up latency: busy, then cpu_load, then cpu_s on successive cycles.
        for (int a = 0; a < DEPTH; a++) shadow[a] = 16'hE000;
        shadow[0] = 16'h1234;
        load_prog();
        pulse_go();
        chk("lat.busy_k1", 64'({busy, cpu_load, cpu_s}), 64'b100);
        @(negedge clk);
        chk("lat.load_k2", 64'({busy, cpu_load, cpu_s}), 64'b110);
        chk("lat.cpu_in", 64'(cpu_in), 64'h1234);
        @(negedge clk);
        chk("lat.s_k3", 64'({busy, cpu_load, cpu_s}), 64'b101);
        check_run("lat", 5'd1, 4'd1, 16'hEDCB, 3'b100, 1'b0);

        // Directed vector table.
        for (int v = 0; v < 5; v++) begin
            for (int a = 0; a < DEPTH; a++) shadow[a] = 16'hE000;
            shadow[0] = vecs[v].w0;
            shadow[1] = vecs[v].w1;
            shadow[2] = vecs[v].w2;
            shadow[3] = vecs[v].w3;
            stub_lat  = vecs[v].lat;
            load_prog();
            pulse_go();
            check_run($sformatf("vec%0d", v), vecs[v].ic, vecs[v].pc, vecs[v].res, vecs[v].fl, 1'b0);
        end

        // Full memory with no HALT: all 16 run, pc stops at 15.
        for (int a = 0; a < DEPTH; a++) shadow[a] = 16'h0100 + 16'(a);
        stub_lat = 3;
        load_prog();
        pulse_go();
        check_run("full", 5'd16, 4'd15, 16'hFEF0, 3'b111, 1'b0);

        // Write and go while busy are ignored.
        pulse_go();
        repeat (10) @(negedge clk);
        prog_we = 1'b1; prog_addr = 4'd5; prog_data = 16'hE000; go = 1'b1;
        @(negedge clk);
        prog_we = 1'b0; go = 1'b0;
        check_run("busy_wr", 5'd16, 4'd15, 16'hFEF0, 3'b111, 1'b0);
        pulse_go();
        check_run("busy_wr_rerun", 5'd16, 4'd15, 16'hFEF0, 3'b111, 1'b0);

        // START timeout: cpu never leaves wait.
        for (int a = 0; a < DEPTH; a++) shadow[a] = 16'hE000;
        shadow[0] = 16'h1234;
        load_prog();
        hang_start = 1'b1;
        pulse_go();
        wait_sig("tmo_start", 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_start.cycles", 64'(n), 64'(TIMEOUT + 1));
        chk("tmo_start.err_s_ic", 64'({err, cpu_s, busy, icount}), 64'({1'b1, 1'b0, 1'b0, 5'd0}));
        hang_start = 1'b0;
        pulse_go();
        check_run("tmo_clear", 5'd1, 4'd0 + 4'd1, 16'hEDCB, 3'b100, 1'b0);

        // RUN timeout: cpu never returns to wait.
        hang_run = 1'b1;
        pulse_go();
        check_run("tmo_run", 5'd0, 4'd0, 16'h0000, 3'b000, 1'b1);
        chk("tmo_run.cpu_s", 64'(cpu_s), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        hang_run = 1'b0;

        // Reset mid-RUN clears outputs immediately; memory survives.
        for (int a = 0; a < DEPTH; a++) shadow[a] = 16'h0100 + 16'(a);
        load_prog();
        pulse_go();
        wait_sig("rst_mid", 1'b1);
        wait_sig("rst_mid", 1'b0);
        chk("rst_mid.in_run", 64'(busy), 64'd1);
        reset = 1'b0;
        #1;
        chk("rst_mid.outputs", out_vec(), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        pulse_go();
        check_run("rst_mid_rerun", 5'd16, 4'd15, 16'hFEF0, 3'b111, 1'b0);

        // Randomized programs against the reference model.
        for (int it = 0; it < 20; it++) begin
            for (int a = 0; a < DEPTH; a++) begin
                if ($urandom_range(0, 5) == 0)
                    shadow[a] = {3'b111, 13'($urandom)};
                else
                    shadow[a] = {3'($urandom_range(0, 6)), 13'($urandom)};
            end
            stub_lat = $urandom_range(1, 4);
            load_prog();
            pulse_go();
            model(e_ic, e_pc, e_res, e_fl, e_cin);
            check_run($sformatf("rnd%0d", it), e_ic, e_pc, e_res, e_fl, 1'b0);
            chk($sformatf("rnd%0d.cpu_in", it), 64'(cpu_in), 64'(e_cin));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
